// File: rtl/edge_capture_pkg.sv
// edge_capture_pkg: shared widths and the FIFO entry layout {stamp, data}
package edge_capture_pkg;
  localparam int STAMP_W = 6;
  localparam int CNT_W = 4;
  localparam int ENTRY_W = STAMP_W + 2;
  typedef struct packed {
    logic [STAMP_W-1:0] stamp;
    logic [1:0] data;
  } capture_entry_t;
endpackage

// File: rtl/edge_capture_if.sv
// edge_capture_if: event read port (rd_valid/rd_ready handshake, rd_data value, rd_stamp timestamp)
interface edge_capture_if #(parameter int STAMP_W = edge_capture_pkg::STAMP_W);
  logic rd_valid;
  logic rd_ready;
  logic [1:0] rd_data;
  logic [STAMP_W-1:0] rd_stamp;
  modport master (output rd_valid, rd_data, rd_stamp, input rd_ready);
  modport slave (input rd_valid, rd_data, rd_stamp, output rd_ready);
endinterface

// File: rtl/capture_fifo.sv
// capture_fifo: circular buffer, ports clk/rst, push/din in, pop/valid/dout out, drop pulses on a refused push
module capture_fifo #(
  parameter int DEPTH = 4,
  parameter int ENTRY_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [ENTRY_W-1:0] din,
  input  logic pop,
  output logic valid,
  output logic [ENTRY_W-1:0] dout,
  output logic drop
);
  localparam int AW = $clog2(DEPTH);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic full, do_pop, do_push;
  assign full = cnt == (AW+1)'(DEPTH);
  assign valid = cnt != '0;
  assign do_pop = pop && valid;
  // a full buffer still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign drop = push && !do_push;
  assign dout = valid ? mem[rp] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + AW'(1);
      end
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/edge_capture.sv
// edge_capture: change-event capture, ports clk/rst, en/in1/in2 sampled, rd event port, rise1/rise2 counts, overflow sticky
module edge_capture #(
  parameter int DEPTH = 4,
  parameter int STAMP_W = edge_capture_pkg::STAMP_W,
  parameter int CNT_W = edge_capture_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in1,
  input  logic in2,
  edge_capture_if.master rd,
  output logic [CNT_W-1:0] rise1,
  output logic [CNT_W-1:0] rise2,
  output logic overflow
);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [1:0] s, cur;
  logic [STAMP_W-1:0] stamp;
  logic [STAMP_W+1:0] head;
  logic ev, pop, drop;
  assign cur = {in2, in1};
  assign ev = en && cur != s;
  assign pop = rd.rd_valid && rd.rd_ready;
  assign {rd.rd_stamp, rd.rd_data} = head;
  capture_fifo #(.DEPTH(DEPTH), .ENTRY_W(STAMP_W + 2)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(ev),
    .din({stamp, cur}),
    .pop(pop),
    .valid(rd.rd_valid),
    .dout(head),
    .drop(drop)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
      stamp <= '0;
      rise1 <= '0;
      rise2 <= '0;
      overflow <= 1'b0;
    end else begin
      if (en) begin
        s <= cur;
        stamp <= stamp + STAMP_W'(1);
        if (in1 && !s[0] && rise1 != MAX) rise1 <= rise1 + CNT_W'(1);
        if (in2 && !s[1] && rise2 != MAX) rise2 <= rise2 + CNT_W'(1);
      end
      if (drop) overflow <= 1'b1;
    end
  end
endmodule
